present_round_ctrl: RTL and testbench
=====================================

// Module: present_round_ctrl
// PURPOSE
//  Sequencer for the round-based, area-optimized PRESENT encryption datapath.
//  Drives the enable of the 64-bit state register, the key register and the
//  datapath muxes (plaintext load vs. round result vs. final whitening).
//  Generates the 5-bit round counter consumed by the key schedule.
//  Provides a start/busy/done handshake to the host.
// PARAMETERS
//  NUM_ROUNDS  31  full rounds (addRoundKey+sBox+pLayer) before final whitening
//  CNT_W       5   round counter width; NUM_ROUNDS < 2**CNT_W required
// PORTS
//  clk        in   1      system clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request encryption; sampled in IDLE and DONE only
//  data_en    out  1      enable of the 64-bit state register
//  key_en     out  1      enable of the key register
//  load_sel   out  1      1: state/key regs take plaintext/user key
//  final_sel  out  1      1: state reg takes state ^ K32 (ciphertext)
//  round_cnt  out  CNT_W  round index fed to key update (0 when idle)
//  busy       out  1      1 in LOAD, ROUND, FINAL
//  done       out  1      one-cycle pulse; ciphertext valid in state reg
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high.
//  Reset: state=IDLE, round_cnt=0; all outputs 0 from the following cycle.
//   The state/key registers are not cleared by this block.
//  FSM states and transitions (Moore; outputs decoded from state):
//   IDLE : start=1 -> LOAD, else stay.
//   LOAD : load_sel=1, data_en=1, key_en=1; round_cnt<=1; -> ROUND.
//   ROUND: data_en=1, key_en=1. If round_cnt==NUM_ROUNDS -> FINAL,
//          round_cnt holds; else round_cnt<=round_cnt+1, stay.
//   FINAL: final_sel=1, data_en=1, key_en=0; round_cnt<=0; -> DONE.
//   DONE : done=1 for this single cycle. start=1 -> LOAD (back-to-back),
//          else -> IDLE.
//  Latency: start sampled at edge t -> LOAD after t; ROUND after
//   t+1..t+31 (round_cnt 1..31); FINAL after t+32; done=1 after t+33.
//  data_en high for exactly NUM_ROUNDS+2 consecutive cycles per operation.
//  key_en high for exactly NUM_ROUNDS+1 consecutive cycles per operation.
//  load_sel and final_sel are mutually exclusive, never both high.
//  start while busy=1 is ignored; no queuing, no error flag.
//  round_cnt never wraps; it is 0 in IDLE/DONE and never exceeds NUM_ROUNDS.
//  rst mid-operation: IDLE next cycle, no done pulse; rst beats start.
// CONFIGURATION
//  PRESENT_ABORT_EN defined: adds input port abort (1 bit). abort=1 in
//   LOAD/ROUND/FINAL -> IDLE next cycle, round_cnt<=0, no done pulse.
//   Priority: rst > abort > start. abort is ignored in IDLE/DONE.
//  PRESENT_ABORT_EN undefined: no abort port; an operation always runs
//   to DONE unless rst is asserted.
// TESTING
//  1. rst 2 cycles, start 1 cycle, key=0, pt=0 with datapath
//     -> done 33 cycles after start edge; state=64'h5579C1387B228445.
//  2. Single start -> round_cnt 1..31 in ROUND cycles; data_en high 33
//     cycles, key_en high 32; load_sel/final_sel one cycle each, never both.
//  3. start held high through operation -> ignored while busy; on DONE
//     it re-enters LOAD next cycle; 2nd done exactly 34 cycles after 1st.
//  4. rst asserted when round_cnt=10 -> next cycle IDLE, busy=0,
//     round_cnt=0, all enables 0; no done pulse within 40 cycles.
//  5. PRESENT_ABORT_EN: abort when round_cnt=5 -> IDLE next cycle,
//     no done; new start then completes normally with done after 33 cycles.

Source files
------------

// File: rtl/present_round_ctrl.sv
// Round sequencer for the round-based PRESENT-80 datapath: LOAD, 31 rounds, FINAL whitening, DONE pulse.
// Optional abort input is compiled in when PRESENT_ABORT_EN is defined.
module present_round_ctrl #(
  parameter int NUM_ROUNDS = 31,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef PRESENT_ABORT_EN
  input  logic             abort,
`endif
  output logic             data_en,
  output logic             key_en,
  output logic             load_sel,
  output logic             final_sel,
  output logic [CNT_W-1:0] round_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

  state_t     state;
  logic [5:0] outs;
  logic       abort_req;

`ifdef PRESENT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Output pattern {data_en, key_en, load_sel, final_sel, busy, done} for each state.
  function automatic logic [5:0] decode(state_t s);
    case (s)
      LOAD:    decode = 6'b111010;
      ROUND:   decode = 6'b110010;
      FINAL:   decode = 6'b100110;
      DONE:    decode = 6'b000001;
      default: decode = 6'b000000;
    endcase
  endfunction

  // Outputs are registered alongside the state so they always equal decode(state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      outs      <= '0;
    end else if (abort_req && busy) begin
      state     <= IDLE;
      round_cnt <= '0;
      outs      <= decode(IDLE);
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            outs  <= decode(LOAD);
          end
        end
        LOAD: begin
          state     <= ROUND;
          round_cnt <= CNT_W'(1);
          outs      <= decode(ROUND);
        end
        ROUND: begin
          if (round_cnt == LAST_ROUND) begin
            state <= FINAL;
            outs  <= decode(FINAL);
          end else begin
            round_cnt <= round_cnt + CNT_W'(1);
          end
        end
        FINAL: begin
          state     <= DONE;
          round_cnt <= '0;
          outs      <= decode(DONE);
        end
        DONE: begin
          if (start) begin
            state <= LOAD;
            outs  <= decode(LOAD);
          end else begin
            state <= IDLE;
            outs  <= decode(IDLE);
          end
        end
        default: begin
          state     <= IDLE;
          round_cnt <= '0;
          outs      <= '0;
        end
      endcase
    end
  end

  assign {data_en, key_en, load_sel, final_sel, busy, done} = outs;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: operation-index reference model plus a
// behavioural PRESENT-80 datapath driven by the controller to confirm the known ciphertext.
module tb_present_round_ctrl;

  localparam int NR = 31;
  localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;
`ifdef PRESENT_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        data_en, key_en, load_sel, final_sel, busy, done;
  logic [4:0]  round_cnt;
  logic [10:0] obs;

  logic [63:0] pt = '0;
  logic [79:0] ukey = '0;
  logic [63:0] dp_state = '0;
  logic [79:0] dp_key = '0;

  int checks = 0;
  int errors = 0;
  int k = -1;

  present_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef PRESENT_ABORT_EN
    .abort    (abort),
`endif
    .data_en  (data_en),
    .key_en   (key_en),
    .load_sel (load_sel),
    .final_sel(final_sel),
    .round_cnt(round_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign obs = {data_en, key_en, load_sel, final_sel, busy, done, round_cnt};

  // Reference: k is the cycle index inside an operation (0 = load, 1..NR rounds,
  // NR+1 = whitening, NR+2 = done pulse), or -1 when no operation is active.
  function automatic logic [10:0] exp_vec(int idx);
    logic [4:0] rc;
    if (idx < 0) return 11'b0;
    if (idx >= 1 && idx <= NR) rc = 5'(idx);
    else if (idx == NR + 1)    rc = 5'(NR);
    else                       rc = 5'd0;
    return {idx <= NR + 1, idx <= NR, idx == 0, idx == NR + 1, idx <= NR + 1, idx == NR + 2, rc};
  endfunction

  task automatic model_step(input logic s, input logic r, input logic a);
    if (r)                                     k = -1;
    else if (ABORT_ON && a && k >= 0 && k <= NR + 1) k = -1;
    else if (k < 0 || k == NR + 2)             k = s ? 0 : -1;
    else                                       k = k + 1;
  endtask

  task automatic tick(input logic s, input logic r, input logic a);
    start = s;
    rst   = r;
    abort = a;
    @(posedge clk);
    model_step(s, r, a);
    #1;
  endtask

  function automatic logic [3:0] sbox(logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [63:0] round_fn(logic [63:0] s, logic [63:0] rk);
    logic [63:0] t, p;
    t = s ^ rk;
    for (int j = 0; j < 16; j++) t[j*4 +: 4] = sbox(t[j*4 +: 4]);
    p = '0;
    for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = t[i];
    return p;
  endfunction

  function automatic logic [79:0] key_upd(logic [79:0] kk, logic [4:0] rc);
    logic [79:0] r;
    r = {kk[18:0], kk[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  // Environment datapath: the state and key registers the controller sequences.
  always @(posedge clk) begin
    if (data_en)
      dp_state <= load_sel  ? pt :
                  final_sel ? (dp_state ^ dp_key[79:16]) :
                              round_fn(dp_state, dp_key[79:16]);
    if (key_en)
      dp_key <= load_sel ? ukey : key_upd(dp_key, round_cnt);
  end

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== 11'b0) begin
        errors++;
        $display("[TB] FAIL reset_state: got %h expected %h", obs, 11'b0);
      end
    end
    tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec(k)) begin
      errors++;
      $display("[TB] FAIL rst_beats_start: got %h expected %h", obs, exp_vec(k));
    end
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_vec(k)) begin
      errors++;
      $display("[TB] FAIL idle_hold: got %h expected %h", obs, exp_vec(k));
    end
  endtask

  task automatic test_single_op;
    int dcnt = 0, kcnt = 0, lcnt = 0, fcnt = 0, both = 0, done_at = -1;
    pt   = '0;
    ukey = '0;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec(k)) begin
        errors++;
        $display("[TB] FAIL single_op_outputs cycle %0d: got %h expected %h", c, obs, exp_vec(k));
      end
      dcnt += int'(data_en);
      kcnt += int'(key_en);
      lcnt += int'(load_sel);
      fcnt += int'(final_sel);
      if (load_sel && final_sel) both++;
      if (done === 1'b1 && done_at < 0) begin
        done_at = c;
        checks++;
        if (dp_state !== CT_ZERO) begin
          errors++;
          $display("[TB] FAIL ciphertext: got %h expected %h", dp_state, CT_ZERO);
        end
      end
    end
    checks++;
    if (done_at != NR + 2) begin
      errors++;
      $display("[TB] FAIL done_latency: got %0d expected %0d", done_at, NR + 2);
    end
    checks++;
    if (dcnt != NR + 2) begin
      errors++;
      $display("[TB] FAIL data_en_cycles: got %0d expected %0d", dcnt, NR + 2);
    end
    checks++;
    if (kcnt != NR + 1) begin
      errors++;
      $display("[TB] FAIL key_en_cycles: got %0d expected %0d", kcnt, NR + 1);
    end
    checks++;
    if (lcnt != 1 || fcnt != 1 || both != 0) begin
      errors++;
      $display("[TB] FAIL sel_pulses: load %0d final %0d both %0d expected 1 1 0", lcnt, fcnt, both);
    end
  endtask

  task automatic test_back_to_back;
    int first = -1, second = -1;
    for (int c = 0; c < 80; c++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec(k)) begin
        errors++;
        $display("[TB] FAIL b2b_outputs cycle %0d: got %h expected %h", c, obs, exp_vec(k));
      end
      if (done === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    checks++;
    if (first < 0 || second - first != NR + 3) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: got first %0d second %0d expected spacing %0d", first, second, NR + 3);
    end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec(k)) begin
        errors++;
        $display("[TB] FAIL b2b_drain cycle %0d: got %h expected %h", c, obs, exp_vec(k));
      end
    end
  endtask

  task automatic test_reset_mid;
    int guard = 0, seen = 0;
    tick(1'b1, 1'b0, 1'b0);
    while (round_cnt !== 5'd10 && guard < 50) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (round_cnt !== 5'd10) begin
      errors++;
      $display("[TB] FAIL rst_mid_reach10: got %0d expected 10 within 50 cycles", round_cnt);
    end
    tick(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_idle: got %h expected %h", obs, 11'b0);
    end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec(k)) begin
        errors++;
        $display("[TB] FAIL rst_mid_after cycle %0d: got %h expected %h", c, obs, exp_vec(k));
      end
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_no_done: got %0d done pulses expected 0", seen);
    end
  endtask

`ifdef PRESENT_ABORT_EN
  task automatic test_abort;
    int guard = 0, seen = 0, done_at = -1;
    tick(1'b1, 1'b0, 1'b0);
    while (round_cnt !== 5'd5 && guard < 50) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (round_cnt !== 5'd5) begin
      errors++;
      $display("[TB] FAIL abort_reach5: got %0d expected 5 within 50 cycles", round_cnt);
    end
    tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got %h expected %h", obs, 11'b0);
    end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses expected 0", seen);
    end
    // abort has no effect in IDLE, so this start is still accepted
    tick(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec(k)) begin
        errors++;
        $display("[TB] FAIL abort_restart cycle %0d: got %h expected %h", c, obs, exp_vec(k));
      end
      if (done === 1'b1 && done_at < 0) done_at = c;
    end
    checks++;
    if (done_at != NR + 2 || dp_state !== CT_ZERO) begin
      errors++;
      $display("[TB] FAIL abort_restart_done: got done at %0d ct %h expected %0d ct %h", done_at, dp_state, NR + 2, CT_ZERO);
    end
  endtask
`endif

  task automatic test_random;
    logic s, r, a;
    for (int c = 0; c < 1500; c++) begin
      s = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 149) == 0);
      a = ABORT_ON && ($urandom_range(0, 39) == 0);
      tick(s, r, a);
      checks++;
      if (obs !== exp_vec(k)) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", c, obs, exp_vec(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_reset_mid();
`ifdef PRESENT_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
